// File: rtl/gray_pkg.sv
// gray_pkg
// Shared constants, the FIFO entry type and the byte-merge helper used by
// the grayscale pixel packer and its output FIFO.
package gray_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // One FIFO entry: end-of-line tag above four packed pixels.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_entry_t;

  // Places the incoming pixel at byte position idx. Only the bytes below
  // idx are taken from the partial register; every byte above idx is zero,
  // so a word forced out early by end-of-line carries zero upper bytes.
  function automatic logic [31:0] merge_byte(input logic [23:0] partial,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  pixel);
    logic [31:0] word;
    case (idx)
      2'd0:    word = {24'h00_0000, pixel};
      2'd1:    word = {16'h0000, pixel, partial[7:0]};
      2'd2:    word = {8'h00, pixel, partial[15:0]};
      2'd3:    word = {pixel, partial[23:0]};
      default: word = {24'h00_0000, pixel};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// gray_word_fifo
// Synchronous FIFO of 33-bit entries (32-bit word plus last flag).
//   clock, nReset : clock and asynchronous active-low reset
//   clear         : synchronous flush, wins over push and pop
//   push, push_entry : write request and entry (ignored when full)
//   pop           : read request (ignored when empty)
//   head_entry    : entry at the read pointer (storage is not reset)
//   level         : number of entries held
//   not_empty, full : status flags derived from level
module gray_word_fifo
  import gray_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [32:0]              push_entry,
  input  logic                     pop,
  output logic [32:0]              head_entry,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     not_empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [32:0]   mem_q [DEPTH];
  logic          do_push_s, do_pop_s;

  assign full       = (level_q == LW'(DEPTH));
  assign not_empty  = (level_q != {LW{1'b0}});
  assign level      = level_q;
  assign head_entry = mem_q[rd_ptr_q];
  assign do_push_s  = push && !full;
  assign do_pop_s   = pop && not_empty;

  // Next-state for pointers and fill counter; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and fill-counter registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; left unreset because contents only matter when counted.
  always_ff @(posedge clock) begin
    if (do_push_s && !clear) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/gray_pixel_packer.sv
// gray_pixel_packer
// Packs 8-bit grayscale pixels little-endian into 32-bit words and queues
// them with an end-of-line tag in an output FIFO.
//   clock, nReset    : clock and asynchronous active-low reset
//   clear            : synchronous flush of packer, FIFO and line position
//   grayValid/grayPixel/grayReady : pixel input handshake
//   wordValid/wordData/wordLast/wordReady : word output handshake
//   fillLevel        : words currently held in the FIFO
module gray_pixel_packer
  import gray_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        nReset,
  input  logic                        clear,
  input  logic                        grayValid,
  input  logic [7:0]                  grayPixel,
  output logic                        grayReady,
  output logic                        wordValid,
  output logic [31:0]                 wordData,
  output logic                        wordLast,
  input  logic                        wordReady,
  output logic [$clog2(FIFO_DEPTH):0] fillLevel
);

  localparam logic [15:0] LAST_PIX  = 16'(LINE_PIXELS - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] partial_q, partial_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;

  logic        accept_s, last_pix_s, push_s, fifo_full_s, fifo_not_empty_s;
  word_entry_t push_entry_s, head_entry_s;

  // Ready depends only on the registered fill level and clear, never on wordReady.
  assign grayReady  = !fifo_full_s && !clear;
  assign accept_s   = grayValid && grayReady;
  assign last_pix_s = (pix_cnt_q == LAST_PIX);
  // The fourth byte, or the final pixel of a line, is merged and pushed at once.
  assign push_s     = accept_s && ((byte_idx_q == LAST_BYTE) || last_pix_s);

  assign push_entry_s.data = merge_byte(partial_q, byte_idx_q, grayPixel);
  assign push_entry_s.last = last_pix_s;

  assign wordValid = fifo_not_empty_s;
  assign wordData  = head_entry_s.data;
  // Storage is unreset, so the tag is masked while the FIFO is empty.
  assign wordLast  = fifo_not_empty_s && head_entry_s.last;

  // Next-state for byte index, partial word and line position.
  always_comb begin
    byte_idx_d = byte_idx_q;
    partial_d  = partial_q;
    pix_cnt_d  = pix_cnt_q;
    if (clear) begin
      byte_idx_d = 2'd0;
      partial_d  = 24'h00_0000;
      pix_cnt_d  = 16'd0;
    end else if (accept_s) begin
      if (push_s) begin
        byte_idx_d = 2'd0;
        partial_d  = 24'h00_0000;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        partial_d  = push_entry_s.data[23:0];
      end
      if (last_pix_s) begin
        pix_cnt_d = 16'd0;
      end else begin
        pix_cnt_d = pix_cnt_q + 16'd1;
      end
    end else begin
      byte_idx_d = byte_idx_q;
      partial_d  = partial_q;
      pix_cnt_d  = pix_cnt_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      byte_idx_q <= 2'd0;
      partial_q  <= 24'h00_0000;
      pix_cnt_q  <= 16'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

  gray_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .nReset     (nReset),
    .clear      (clear),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (wordReady),
    .head_entry (head_entry_s),
    .level      (fillLevel),
    .not_empty  (fifo_not_empty_s),
    .full       (fifo_full_s)
  );

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Scoreboard bench: dut_a (8-pixel lines, 4-word FIFO) and dut_b (6-pixel
// lines, 8-word FIFO). Stimulus pushes hand-computed {last,data} words into
// per-DUT queues; negedge monitors pop and compare on every output handshake.
module tb_gray_pixel_packer;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  logic        a_clear = 1'b0, a_valid = 1'b0, a_wready = 1'b0;
  logic [7:0]  a_pixel = 8'h00;
  logic        a_gready, a_wvalid, a_wlast;
  logic [31:0] a_wdata;
  logic [2:0]  a_fill;

  logic        b_clear = 1'b0, b_valid = 1'b0, b_wready = 1'b0;
  logic [7:0]  b_pixel = 8'h00;
  logic        b_gready, b_wvalid, b_wlast;
  logic [31:0] b_wdata;
  logic [3:0]  b_fill;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] a_exp, b_exp;
  int n_checks = 0;
  int n_fail   = 0;

  gray_pixel_packer #(.LINE_PIXELS(8), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .nReset(nReset), .clear(a_clear),
    .grayValid(a_valid), .grayPixel(a_pixel), .grayReady(a_gready),
    .wordValid(a_wvalid), .wordData(a_wdata), .wordLast(a_wlast),
    .wordReady(a_wready), .fillLevel(a_fill)
  );

  gray_pixel_packer #(.LINE_PIXELS(6), .FIFO_DEPTH(8)) dut_b (
    .clock(clock), .nReset(nReset), .clear(b_clear),
    .grayValid(b_valid), .grayPixel(b_pixel), .grayReady(b_gready),
    .wordValid(b_wvalid), .wordData(b_wdata), .wordLast(b_wlast),
    .wordReady(b_wready), .fillLevel(b_fill)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut_a: a pop happens at the next posedge.
  always @(negedge clock) begin
    if (nReset && !a_clear && a_wvalid && a_wready) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_word: got %h_%h, expected none", a_wlast, a_wdata);
      end else begin
        a_exp = qa.pop_front();
        chk("a_word", {31'd0, a_wlast, a_wdata}, {31'd0, a_exp});
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clock) begin
    if (nReset && !b_clear && b_wvalid && b_wready) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_word: got %h_%h, expected none", b_wlast, b_wdata);
      end else begin
        b_exp = qb.pop_front();
        chk("b_word", {31'd0, b_wlast, b_wdata}, {31'd0, b_exp});
      end
    end
  end

  // Offer one pixel until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] p);
    bit done = 1'b0;
    if (sel) begin b_valid = 1'b1; b_pixel = p; end
    else     begin a_valid = 1'b1; a_pixel = p; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      done = sel ? b_gready : a_gready;
      @(posedge clock);
      #1;
    end
    if (sel) b_valid = 1'b0;
    else     a_valid = 1'b0;
    chk("send_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_empty(input bit sel);
    bit empty = 1'b0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(negedge clock);
      empty = sel ? (b_fill == 4'd0) : (a_fill == 3'd0);
    end
    @(posedge clock);
    #1;
    chk("drain_empty", {63'd0, empty}, 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_wvalid", {63'd0, a_wvalid}, 64'd0);
    chk("rst_fill", {61'd0, a_fill}, 64'd0);
    #10 nReset = 1'b1;
    @(posedge clock); #1;
    chk("rst_gready", {63'd0, a_gready}, 64'd1);
    chk("rst_wlast", {63'd0, a_wlast}, 64'd0);
    chk("rst_fill_b", {60'd0, b_fill}, 64'd0);

    // Basic packing, one line of 8 pixels
    a_wready = 1'b1;
    qa.push_back({1'b0, 32'h4433_2211});
    qa.push_back({1'b1, 32'h8877_6655});
    send(1'b0, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33);
    chk("pack_not_yet", {63'd0, a_wvalid}, 64'd0);
    send(1'b0, 8'h44);
    chk("pack_latency_valid", {63'd0, a_wvalid}, 64'd1);
    chk("pack_latency_data", {32'd0, a_wdata}, 64'h4433_2211);
    chk("pack_latency_fill", {61'd0, a_fill}, 64'd1);
    send(1'b0, 8'h55); send(1'b0, 8'h66); send(1'b0, 8'h77); send(1'b0, 8'h88);
    chk("pack_last_valid", {63'd0, a_wvalid}, 64'd1);
    chk("pack_last_tag", {63'd0, a_wlast}, 64'd1);
    wait_empty(1'b0);

    // Backpressure: 16 pixels fill the 4-word FIFO
    a_wready = 1'b0;
    qa.push_back({1'b0, 32'h0403_0201});
    qa.push_back({1'b1, 32'h0807_0605});
    qa.push_back({1'b0, 32'h0c0b_0a09});
    qa.push_back({1'b1, 32'h100f_0e0d});
    for (int i = 1; i <= 16; i++) send(1'b0, 8'(i));
    chk("full_gready", {63'd0, a_gready}, 64'd0);
    chk("full_fill", {61'd0, a_fill}, 64'd4);
    a_valid = 1'b1; a_pixel = 8'h99;
    repeat (3) begin
      @(negedge clock);
      chk("stall_gready", {63'd0, a_gready}, 64'd0);
      chk("stall_fill", {61'd0, a_fill}, 64'd4);
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
    a_wready = 1'b1;
    wait_empty(1'b0);
    chk("drained_gready", {63'd0, a_gready}, 64'd1);

    // Simultaneous push and pop at fillLevel 2
    a_wready = 1'b0;
    qa.push_back({1'b0, 32'h2423_2221});
    qa.push_back({1'b1, 32'h2827_2625});
    qa.push_back({1'b0, 32'h3433_3231});
    for (int i = 8'h21; i <= 8'h28; i++) send(1'b0, 8'(i));
    chk("pp_fill_before", {61'd0, a_fill}, 64'd2);
    send(1'b0, 8'h31); send(1'b0, 8'h32); send(1'b0, 8'h33);
    a_wready = 1'b1;
    send(1'b0, 8'h34);
    a_wready = 1'b0;
    chk("pp_fill_after", {61'd0, a_fill}, 64'd2);
    a_wready = 1'b1;
    wait_empty(1'b0);

    // Clear mid-word: also resets line position
    send(1'b0, 8'hAA); send(1'b0, 8'hBB);
    a_clear = 1'b1;
    @(negedge clock);
    chk("clear_gready", {63'd0, a_gready}, 64'd0);
    @(posedge clock); #1;
    a_clear = 1'b0;
    chk("clear_fill", {61'd0, a_fill}, 64'd0);
    chk("clear_wvalid", {63'd0, a_wvalid}, 64'd0);
    qa.push_back({1'b0, 32'h0403_0201});
    qa.push_back({1'b1, 32'h0807_0605});
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i));
    wait_empty(1'b0);

    // Asynchronous reset with 3 words and a partial byte buffered
    a_wready = 1'b0;
    for (int i = 8'h41; i <= 8'h4D; i++) send(1'b0, 8'(i));
    chk("pre_reset_fill", {61'd0, a_fill}, 64'd3);
    #3 nReset = 1'b0;
    #1;
    chk("async_wvalid", {63'd0, a_wvalid}, 64'd0);
    chk("async_fill", {61'd0, a_fill}, 64'd0);
    chk("async_wlast", {63'd0, a_wlast}, 64'd0);
    #2 nReset = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_gready", {63'd0, a_gready}, 64'd1);
    a_wready = 1'b1;
    qa.push_back({1'b0, 32'h5453_5251});
    qa.push_back({1'b1, 32'h5857_5655});
    for (int i = 8'h51; i <= 8'h58; i++) send(1'b0, 8'(i));
    wait_empty(1'b0);

    // Partial final word on a 6-pixel line, then a fresh word
    b_wready = 1'b1;
    qb.push_back({1'b0, 32'h0403_0201});
    qb.push_back({1'b1, 32'h0000_0605});
    qb.push_back({1'b0, 32'h0A09_0807});
    for (int i = 1; i <= 6; i++) send(1'b1, 8'(i));
    chk("b_last_tag", {63'd0, b_wlast}, 64'd1);
    chk("b_last_data", {32'd0, b_wdata}, 64'h0000_0605);
    for (int i = 7; i <= 10; i++) send(1'b1, 8'(i));
    wait_empty(1'b1);

    chk("qa_all_seen", 64'(qa.size()), 64'd0);
    chk("qb_all_seen", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
